// File: rtl/alu_seq_pkg.sv
// Shared constants for the multi-byte ALU sequencer: ALU SEL op codes, idle SEL, FSM states.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDC = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBC = 4'b0011;
  localparam logic [3:0] OP_CMP  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_EXOR = 4'b0111;
  localparam logic [3:0] OP_TEST = 4'b1000;
  localparam logic [3:0] OP_LSL  = 4'b1001;
  localparam logic [3:0] OP_LSR  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1101;
  localparam logic [3:0] OP_MOV  = 4'b1110;

  localparam logic [3:0] SEL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Per-byte op decode: ALU SEL/CIN for the current byte, byte order, supported and flags-only.
// Combinational, zero latency; no flow control.
// CMP/TEST are only decoded as supported when ALU_SEQ_CMP_EN is defined.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       first,
  input  logic       carry,
  input  logic       lsr_bit,
  input  logic       c_in,
  output logic [3:0] sel,
  output logic       cin,
  output logic       msb_first,
  output logic       supported,
  output logic       flags_only,
  output logic       logic_op
);

  always_comb begin
    sel        = op;
    cin        = 1'b0;
    msb_first  = 1'b0;
    supported  = 1'b0;
    flags_only = 1'b0;
    logic_op   = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        supported = 1'b1;
        sel       = first ? op : OP_ADDC;
        cin       = first ? (c_in & (op == OP_ADDC)) : carry;
      end
      OP_SUB, OP_SUBC: begin
        supported = 1'b1;
        sel       = first ? op : OP_SUBC;
        cin       = first ? (c_in & (op == OP_SUBC)) : carry;
      end
      OP_AND, OP_OR, OP_EXOR: begin
        supported = 1'b1;
        logic_op  = 1'b1;
      end
      OP_LSL: begin
        supported = 1'b1;
        cin       = first ? c_in : carry;
      end
      // LSR walks MSB first; the bit shifted in is bit 0 of the byte above
      OP_LSR: begin
        supported = 1'b1;
        msb_first = 1'b1;
        cin       = first ? c_in : lsr_bit;
      end
`ifdef ALU_SEQ_CMP_EN
      OP_CMP: begin
        supported  = 1'b1;
        flags_only = 1'b1;
        sel        = first ? op : OP_SUBC;
        cin        = first ? 1'b0 : carry;
      end
      OP_TEST: begin
        supported  = 1'b1;
        flags_only = 1'b1;
        logic_op   = 1'b1;
      end
`else
      OP_CMP, OP_TEST: supported = 1'b0;
`endif
      OP_ROL, OP_ROR, OP_ASR, OP_MOV, SEL_IDLE: supported = 1'b0;
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte op sequencer driving the external 8-bit ALU one byte per clock (ALU_SEQ_CMP_EN adds CMP/TEST).
// Latency N_BYTES+1 cycles from START to DONE; unsupported ops complete in 1 cycle with ERR.
// No queueing: START is only sampled in IDLE and ignored while BUSY.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N_BYTES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [3:0]           OP,
  input  logic [8*N_BYTES-1:0] OPA,
  input  logic [8*N_BYTES-1:0] OPB,
  input  logic                 C_IN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [8*N_BYTES-1:0] RESULT,
  output logic                 C_OUT,
  output logic                 Z_OUT,
  output logic [3:0]           ALU_SEL,
  output logic [7:0]           ALU_A,
  output logic [7:0]           ALU_B,
  output logic                 ALU_CIN,
  input  logic [7:0]           ALU_RESULT,
  input  logic                 ALU_C,
  input  logic                 ALU_Z
);

  localparam int W = 8 * N_BYTES;
  localparam logic [2:0] LAST_IDX = 3'(N_BYTES - 1);

  state_t         state;
  logic [3:0]     op_q;
  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic           cin_q;
  logic [2:0]     idx;
  logic           carry_q;
  logic           zacc_q;
  logic [W-1:0]   shadow_q;

  logic [3:0]     dec_op;
  logic [3:0]     dec_sel;
  logic           dec_cin;
  logic           msb_first;
  logic           supported;
  logic           flags_only;
  logic           logic_op;
  logic           is_first;
  logic           is_last;
  logic [2:0]     pos;
  logic [7:0]     a_byte;
  logic [7:0]     b_byte;
  logic           lsr_bit;
  logic [W-1:0]   shadow_next;
  logic           zacc_next;
  logic           c_final;

  // In IDLE the incoming OP is decoded so the supported check can steer the first transition
  assign dec_op   = (state == ST_IDLE) ? OP : op_q;
  assign is_first = (idx == 3'd0);
  assign is_last  = (idx == LAST_IDX);
  assign pos      = msb_first ? (LAST_IDX - idx) : idx;

  alu_seq_decode u_decode (
    .op         (dec_op),
    .first      (is_first),
    .carry      (carry_q),
    .lsr_bit    (lsr_bit),
    .c_in       (cin_q),
    .sel        (dec_sel),
    .cin        (dec_cin),
    .msb_first  (msb_first),
    .supported  (supported),
    .flags_only (flags_only),
    .logic_op   (logic_op)
  );

  always_comb begin
    a_byte      = '0;
    b_byte      = '0;
    lsr_bit     = 1'b0;
    shadow_next = shadow_q;
    for (int i = 0; i < N_BYTES; i++) begin
      if (pos == 3'(i)) begin
        a_byte                = opa_q[8*i +: 8];
        b_byte                = opb_q[8*i +: 8];
        shadow_next[8*i +: 8] = ALU_RESULT;
      end
    end
    for (int i = 0; i < N_BYTES - 1; i++) begin
      if (pos == 3'(i)) lsr_bit = opa_q[8*i + 8];
    end
    zacc_next = is_first ? ALU_Z : (zacc_q & ALU_Z);
  end

  // LSR's carry-out is the bit shifted off the bottom, independent of the ALU's own C
  assign c_final = msb_first ? opa_q[0] : (logic_op ? 1'b0 : ALU_C);

  always_comb begin
    ALU_SEL = SEL_IDLE;
    ALU_A   = '0;
    ALU_B   = '0;
    ALU_CIN = 1'b0;
    if (state == ST_EXEC) begin
      ALU_SEL = dec_sel;
      ALU_A   = a_byte;
      ALU_B   = b_byte;
      ALU_CIN = dec_cin;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      idx      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      RESULT   <= '0;
      C_OUT    <= 1'b0;
      Z_OUT    <= 1'b0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          DONE <= 1'b0;
          ERR  <= 1'b0;
          if (START) begin
            op_q     <= OP;
            opa_q    <= OPA;
            opb_q    <= OPB;
            cin_q    <= C_IN;
            idx      <= '0;
            shadow_q <= '0;
            BUSY     <= 1'b1;
            if (supported) begin
              state <= ST_EXEC;
            end else begin
              state <= ST_DONE;
              DONE  <= 1'b1;
              ERR   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          shadow_q <= shadow_next;
          zacc_q   <= zacc_next;
          carry_q  <= ALU_C;
          idx      <= idx + 3'd1;
          if (is_last) begin
            state <= ST_DONE;
            DONE  <= 1'b1;
            C_OUT <= c_final;
            Z_OUT <= zacc_next;
            if (!flags_only) RESULT <= shadow_next;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          ERR   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-byte operation sequencer for the 8-bit RAT ALU. It accepts one wide operation, with operands of N_BYTES bytes, from a requester. It then drives the shared combinational ALU one byte per clock, chaining the carry between bytes, and returns a wide result with C and Z flags. It sits between the control unit (or a coprocessor port) and the ALU instance, which stays outside this block.

## Interface
Parameters:
- N_BYTES, 2: operand width in bytes; legal range 2–8.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- OP  in  4  operation, using ALU SEL encoding.
- OPA  in  8*N_BYTES  operand A; byte 0 is least significant.
- OPB  in  8*N_BYTES  operand B.
- C_IN  in  1  incoming carry, used by ADDC, SUBC, LSL and LSR.
- BUSY  out  1  high from the cycle after START is accepted through the DONE cycle.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse, coincident with DONE, for an unsupported OP.
- RESULT  out  8*N_BYTES  registered wide result.
- C_OUT  out  1  registered carry/borrow.
- Z_OUT  out  1  registered zero flag; 1 when all result bytes are zero.
- ALU_SEL  out  4  SEL drive to the ALU.
- ALU_A  out  8  A drive to the ALU.
- ALU_B  out  8  B drive to the ALU.
- ALU_CIN  out  1  CIN drive to the ALU.
- ALU_RESULT  in  8  ALU result, same cycle.
- ALU_C  in  1  ALU carry, same cycle.
- ALU_Z  in  1  ALU zero, same cycle.

## Operation
- States: IDLE → EXEC → DONE → IDLE.
- IDLE:
  - START=1 latches OP, OPA, OPB and C_IN, clears the byte index, and moves to EXEC.
  - A supported OP moves to EXEC; an unsupported OP goes straight to DONE.
- EXEC: one byte per cycle, N_BYTES cycles.
  - Byte order is LSB first for ADD, ADDC, SUB, SUBC, AND, OR, EXOR and LSL.
  - Byte order is MSB first for LSR.
- ALU_SEL per operation:
  - ADD/ADDC: first byte uses OP, later bytes use ADDC (0001).
  - SUB/SUBC: first byte uses OP, later bytes use SUBC (0011).
  - Logic ops: OP on every byte.
- ALU_CIN per operation:
  - First byte: latched C_IN for ADDC, SUBC, LSL and LSR; 0 otherwise.
  - Later bytes, arithmetic and LSL: the ALU_C captured on the previous byte.
  - Later bytes, LSR: bit 0 of the previous (more significant) operand A byte.
- Byte capture: ALU_RESULT is written into the matching byte of the result shadow; a zero accumulator ANDs ALU_Z across bytes.
- Final C_OUT:
  - Arithmetic and LSL: ALU_C of the last byte.
  - LSR: bit 0 of operand A byte 0. The ALU's own C is ignored for LSR.
  - Logic ops: 0.
- DONE state:
  - RESULT, C_OUT and Z_OUT update from the shadow; DONE=1.
  - Unsupported OP (1001 excepted, i.e. LSL is supported): ERR=1, and RESULT, C_OUT and Z_OUT keep their previous values.
- Unsupported OP set: ROL, ROR, ASR, MOV and 1111; also CMP and TEST when the compare feature is compiled out.
- ALU drive outside EXEC: ALU_SEL=1111; ALU_A, ALU_B and ALU_CIN = 0.
- START while BUSY is ignored; there is no queueing.

## Timing
- Reset values: state IDLE, byte index 0, BUSY=0, DONE=0, ERR=0, RESULT=0, C_OUT=0, Z_OUT=0, ALU_SEL=1111, ALU_A, ALU_B and ALU_CIN = 0.
- Latency, supported op: START is accepted at edge 0; DONE is high in cycle N_BYTES+1 (cycle 3 for N_BYTES=2). RESULT, C_OUT and Z_OUT are valid in the DONE cycle and hold until the next completion.
- Latency, unsupported op: DONE and ERR are high in cycle 1.
- Throughput: a new START is accepted at the earliest in the cycle after DONE; minimum spacing is N_BYTES+2 cycles.
- ALU path: ALU outputs are sampled at the end of the same cycle the drive is applied (single-cycle combinational ALU).
- RST mid-operation: abort immediately, no DONE, all outputs return to reset values, and latched operands are discarded.

## Configuration
- ALU_SEQ_CMP_EN defined: CMP (0100) and TEST (1000) are supported.
  - CMP is sequenced like SUB; TEST is sequenced like AND.
  - Only C_OUT and Z_OUT update at DONE; RESULT is unchanged.
- ALU_SEQ_CMP_EN undefined: CMP and TEST take the unsupported path (1-cycle DONE+ERR, no output change).

## Structure
- Package alu_seq_pkg holds:
  - The 4-bit op constants, matching the ALU SEL encoding (ADD=0000 … MOV=1110).
  - The state enum.
  - The idle SEL constant, 1111.
- Sub-module alu_seq_decode (combinational): takes OP, the first-byte flag, the chained carry and the LSR chain bit. It produces ALU_SEL, ALU_CIN, the byte order, and the supported and flags-only indications.

## Test plan
All cases use N_BYTES=2.
- ADD, OPA=0x00FF, OPB=0x0001, C_IN=0 → RESULT=0x0100, C_OUT=0, Z_OUT=0, DONE in cycle 3, BUSY high in cycles 1–3.
- SUB, OPA=0x0000, OPB=0x0001 → RESULT=0xFFFF, C_OUT=1, Z_OUT=0; ALU_SEL sequence 0010 then 0011.
- AND, OPA=0xF0F0, OPB=0x0F0F → RESULT=0x0000, Z_OUT=1, C_OUT=0.
- LSR, OPA=0x8001, C_IN=1 → RESULT=0xC000, C_OUT=1; the high byte is driven first.
- OP=1110 → DONE and ERR in cycle 1 with outputs unchanged; a START pulse during a running ADD is ignored and exactly one DONE is seen.
- RST asserted in cycle 2 of an ADD → no DONE and all outputs at reset values; with ALU_SEQ_CMP_EN, CMP 0x1234 vs 0x1234 → Z_OUT=1, C_OUT=0, RESULT unchanged.
